// File: rtl/stream_fifo_reader.sv
// stream_fifo_reader: circular-buffer FIFO with valid/ready on both sides and a registered, pre-fetched output word
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     producer handshake, in_data written on push
//   out_valid/out_ready   consumer handshake, out_data holds the oldest unread word
//   count                 words stored, including the one on out_data
//   full, empty           count == DEPTH, count == 0
module stream_fifo_reader #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  typedef enum logic {S_EMPTY, S_HOLD} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] stored;
  logic push, pop, load, bypass;
  assign out_valid = state == S_HOLD;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign in_ready = !full;
  assign push = in_valid & in_ready;
  assign pop = out_valid & out_ready;
  // words still in the array, not yet moved into the output register
  assign stored = count - (AW+1)'(out_valid);
  always_comb begin
    load = (!out_valid | pop) & (stored != '0);
    // last word leaves while a new one arrives: forward it straight to out_data
    bypass = pop & push & (stored == '0);
    state_nx = (load | bypass | (out_valid & !pop)) ? S_HOLD : S_EMPTY;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_EMPTY;
    else state <= state_nx;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      out_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push & !bypass);
      rd_ptr <= rd_ptr + AW'(load);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      out_data <= load ? mem[rd_ptr] : bypass ? in_data : out_data;
    end
  always_ff @(posedge clk)
    if (push & !bypass) mem[wr_ptr] <= in_data;
endmodule

// File: tb/tb_stream_fifo_reader.sv
// tb_stream_fifo_reader: table, directed and random checks of stream_fifo_reader against a queue model
module tb_stream_fifo_reader;
  localparam int DEPTH = 16;
  localparam int WIDTH = 64;
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, full, empty;
  logic [WIDTH-1:0] in_data = '0, out_data;
  logic [4:0] count;
  int n_vec = 0, n_err = 0;
  logic [WIDTH-1:0] q[$];
  bit mv = 0;
  typedef struct {bit iv; logic [63:0] d; bit ordy; int cnt; bit vld; logic [63:0] dat;} vec_t;
  vec_t tbl[8];
  stream_fifo_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  task automatic check_model();
    chk("count", 64'(count), 64'(q.size()));
    chk("full", 64'(full), 64'(q.size() == DEPTH));
    chk("empty", 64'(empty), 64'(q.size() == 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
    chk("out_valid", 64'(out_valid), 64'(mv));
    if (mv) chk("out_data", out_data, q[0]);
  endtask
  // one clock: accepted/taken words follow the handshake rules; the head word becomes
  // visible one cycle after it enters an empty FIFO, otherwise it is visible at once
  task automatic step(input bit iv, input logic [63:0] d, input bit ordy);
    bit push, pop;
    int prev;
    in_valid = iv;
    in_data = d;
    out_ready = ordy;
    push = iv && q.size() < DEPTH;
    pop = ordy && mv;
    @(posedge clk);
    prev = q.size();
    if (pop) void'(q.pop_front());
    if (push) q.push_back(d);
    mv = q.size() > 0 && !(prev == 0 && push);
    #1 check_model();
  endtask
  task automatic do_reset();
    rst = 1;
    q.delete();
    mv = 0;
    @(posedge clk);
    #1 rst = 0;
  endtask
  initial begin
    tbl[0] = '{1, 64'hA5, 0, 1, 0, 0};
    tbl[1] = '{0, 64'h0, 0, 1, 1, 64'hA5};
    tbl[2] = '{1, 64'h11, 0, 2, 1, 64'hA5};
    tbl[3] = '{1, 64'h22, 1, 2, 1, 64'h11};
    tbl[4] = '{0, 64'h0, 1, 1, 1, 64'h22};
    tbl[5] = '{1, 64'h33, 1, 1, 1, 64'h33};
    tbl[6] = '{0, 64'h0, 1, 0, 0, 0};
    tbl[7] = '{0, 64'h0, 1, 0, 0, 0};
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check_model();
    chk("reset_out_data", out_data, 64'h0);
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].ordy);
      chk("tbl_count", 64'(count), 64'(tbl[i].cnt));
      chk("tbl_valid", 64'(out_valid), 64'(tbl[i].vld));
      if (tbl[i].vld) chk("tbl_data", out_data, tbl[i].dat);
    end
    for (int i = 0; i < 16; i++) step(1, 64'(i), 0);
    chk("fill_full", 64'(full), 64'h1);
    chk("fill_in_ready", 64'(in_ready), 64'h0);
    chk("fill_count", 64'(count), 64'd16);
    for (int i = 0; i < 16; i++) begin
      chk("drain_word", out_data, 64'(i));
      step(0, 0, 1);
    end
    chk("drain_empty", 64'(empty), 64'h1);
    for (int i = 0; i < 16; i++) step(1, 64'(100 + i), 0);
    step(1, 64'hDEAD, 1);
    chk("full_pushpop_count", 64'(count), 64'd15);
    chk("full_pushpop_head", out_data, 64'd101);
    step(1, 64'hBEEF, 1);
    chk("full_pushpop2_count", 64'(count), 64'd15);
    while (q.size() > 0) step(0, 0, 1);
    step(0, 0, 0);
    for (int i = 1; i <= 100; i++) begin
      step(1, 64'(i), 1);
      chk("stream_count_le2", 64'(count <= 2), 64'h1);
    end
    step(0, 0, 1);
    chk("stream_tail", out_data, 64'd100);
    while (q.size() > 0) step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 64'(200 + i), 0);
    #2 rst = 1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'h0);
    chk("arst_count", 64'(count), 64'h0);
    chk("arst_empty", 64'(empty), 64'h1);
    chk("arst_in_ready", 64'(in_ready), 64'h1);
    chk("arst_out_data", out_data, 64'h0);
    do_reset();
    check_model();
    for (int i = 0; i < 10000; i++) begin
      bit iv, ordy;
      iv = (i < 5000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      ordy = (i < 5000) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step(iv, {$urandom, $urandom}, ordy);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
